memory_bank_controller: RTL
===========================

MEMORY_BANK_CONTROLLER -- requirements
Module: memory_bank_controller

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 10, byte-address width; depth = 2^(ADDRESS_WIDTH-2) 32-bit words.
REQ-002 SHALL have parameter ONLY_ALLOW_WORDS, default 0; when 1, req_size is treated as 2 and req_address[1:0] as 0.
REQ-003 SHALL have parameter ALLOW_MISALIGNED, default 1; when 1, misaligned accesses are split into two word accesses; when 0, they are errors.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  controller accepts request this cycle.
REQ-009 req_address  input  ADDRESS_WIDTH  byte address.
REQ-010 req_size  input  2  0 byte, 1 half-word, 2 word, 3 illegal.
REQ-011 req_write  input  1  1 write, 0 read.
REQ-012 req_unsigned  input  1  reads: 1 zero-extend, 0 sign-extend.
REQ-013 req_write_value  input  32  write data, little-endian, LSB-aligned.
REQ-014 resp_valid  output  1  one-cycle completion pulse, reads and writes.
REQ-015 resp_read_value  output  32  extended read data; 0 for writes and errors.
REQ-016 resp_error  output  1  valid with resp_valid; illegal size or disallowed misalignment.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; all request fields are sampled on that edge.
REQ-018 SHALL use states IDLE and SPLIT; req_ready = 1 in IDLE, 0 in SPLIT.
REQ-019 Aligned access (byte; half with addr[0]=0; word with addr[1:0]=0) SHALL complete in one cycle: resp_valid high the cycle after acceptance; state stays IDLE.
REQ-020 Misaligned access (half with addr[1:0]=3; word with addr[1:0]!=0), when ALLOW_MISALIGNED=1, SHALL enter SPLIT: low bytes at word A in the acceptance cycle, high bytes at word A+1 in the SPLIT cycle, resp_valid one cycle later (2-cycle latency), then return to IDLE.
REQ-021 Word index A+1 SHALL wrap modulo depth (last word -> word 0).
REQ-022 Writes SHALL update only the addressed bytes; other bytes of the affected words are unchanged.
REQ-023 Reads SHALL return the byte at req_address in bits [7:0] and higher addresses in higher bits, extended to 32 bits per req_unsigned and req_size.
REQ-024 req_size=3, or misalignment with ALLOW_MISALIGNED=0, SHALL assert resp_error with resp_valid one cycle after acceptance, leave memory unchanged, and output resp_read_value 0.
REQ-025 resp_valid SHALL be a single-cycle pulse with no backpressure; resp_error and resp_read_value are 0 when resp_valid is 0.
REQ-026 Back-to-back aligned requests SHALL sustain one per cycle; a read immediately after a write to the same address returns the new data.

Reset
REQ-027 While reset is high: all memory words cleared to 0, state IDLE, resp_valid=0, resp_error=0, resp_read_value=0, req_ready=0; req_ready=1 in the first cycle after reset deasserts.
REQ-028 Reset asserted in SPLIT SHALL abort the access with no response; the memory is still cleared.

Verification
REQ-029 Reset, then read word at 0x000 -> resp_valid next cycle, value 0x00000000, resp_error 0.
REQ-030 Write word 0x80FF1234 at 0x010, read byte 0x013 signed -> 0xFFFFFF80; unsigned -> 0x00000080; read half 0x010 signed -> 0x00001234.
REQ-031 Write word 0xAABBCCDD at 0x006 (ALLOW_MISALIGNED=1) -> req_ready low one cycle, resp_valid 2 cycles after accept; word read at 0x004 -> 0xCCDD0000, at 0x008 -> 0x0000AABB.
REQ-032 Word write 0x11223344 at last address 0x3FE, ADDRESS_WIDTH=10 -> bytes 0x44,0x33 at 0x3FE/0x3FF, 0x22,0x11 at 0x000/0x001.
REQ-033 req_size=3 write, or misaligned word with ALLOW_MISALIGNED=0 -> resp_error=1, resp_read_value=0, memory unchanged on readback.
REQ-034 Reset asserted during SPLIT of a misaligned write -> no resp_valid, req_ready=1 after reset, all reads return 0.

Source files
------------

// File: rtl/memory_bank_controller_if.sv
// rtl/memory_bank_controller_if.sv - request/response bus between a requester and the memory bank controller
//
// Signals:
//   req_valid/req_ready          request handshake, accepted when both are high on a rising edge
//   req_address                  byte address (ADDRESS_WIDTH bits)
//   req_size                     0 byte, 1 half-word, 2 word, 3 illegal
//   req_write                    1 write, 0 read
//   req_unsigned                 reads: 1 zero-extend, 0 sign-extend
//   req_write_value              little-endian write data, LSB-aligned
//   resp_valid                   one-cycle completion pulse
//   resp_read_value              extended read data, 0 for writes and errors
//   resp_error                   illegal size or disallowed misalignment
// Modports: master drives requests, slave is the controller.
interface memory_bank_controller_if #(
    parameter int ADDRESS_WIDTH = 10
);
    logic                     req_valid;
    logic                     req_ready;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic [1:0]               req_size;
    logic                     req_write;
    logic                     req_unsigned;
    logic [31:0]              req_write_value;
    logic                     resp_valid;
    logic [31:0]              resp_read_value;
    logic                     resp_error;

    modport master (
        output req_valid, req_address, req_size, req_write, req_unsigned, req_write_value,
        input  req_ready, resp_valid, resp_read_value, resp_error
    );

    modport slave (
        input  req_valid, req_address, req_size, req_write, req_unsigned, req_write_value,
        output req_ready, resp_valid, resp_read_value, resp_error
    );
endinterface

// File: rtl/memory_bank_controller.sv
// rtl/memory_bank_controller.sv - single-bank byte-addressable word memory with split misaligned access
//
// Ports:
//   clock   sole clock, all state updates on the rising edge
//   reset   synchronous active-high reset; clears every memory word
//   bus     memory_bank_controller_if.slave request/response bus
// Parameters:
//   ADDRESS_WIDTH     byte-address width, depth is 2^(ADDRESS_WIDTH-2) words
//   ONLY_ALLOW_WORDS  1: every request is treated as an aligned word access
//   ALLOW_MISALIGNED  1: word-crossing accesses take two cycles, 0: they are errors
module memory_bank_controller #(
    parameter int ADDRESS_WIDTH    = 10,
    parameter bit ONLY_ALLOW_WORDS = 1'b0,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    memory_bank_controller_if.slave  bus
);
    localparam int WORD_W = ADDRESS_WIDTH - 2;
    localparam int DEPTH  = 1 << WORD_W;

    typedef enum logic {ST_IDLE, ST_SPLIT} state_t;

    state_t              state_q, state_d;
    logic [31:0]         mem_q [DEPTH];

    logic                resp_valid_q, resp_valid_d;
    logic                resp_error_q, resp_error_d;
    logic [31:0]         resp_data_q,  resp_data_d;

    // Context of a word-crossing access carried into the second cycle.
    logic [WORD_W-1:0]   sp_widx_q, sp_widx_d;
    logic [1:0]          sp_off_q, sp_off_d;
    logic [1:0]          sp_size_q, sp_size_d;
    logic                sp_write_q, sp_write_d;
    logic                sp_unsigned_q, sp_unsigned_d;
    logic [31:0]         sp_wdata_q, sp_wdata_d;
    logic [31:0]         sp_rdata_q, sp_rdata_d;

    // Per-lane write port into one memory word.
    logic [3:0]          mem_we;
    logic [WORD_W-1:0]   mem_widx;
    logic [31:0]         mem_wdata;

    logic                accept;
    logic [1:0]          eff_size;
    logic [1:0]          eff_off;
    logic [WORD_W-1:0]   req_widx;
    logic                crosses;
    logic                illegal;
    logic [31:0]         rbytes;
    int                  lane;

    function automatic logic [2:0] nbytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] b, input logic [1:0] sz, input logic uns);
        case (sz)
            2'd0:    return {{24{~uns & b[7]}}, b[7:0]};
            2'd1:    return {{16{~uns & b[15]}}, b[15:0]};
            default: return b;
        endcase
    endfunction

    // Ready is forced low while reset is held so nothing is accepted during it.
    assign bus.req_ready = (state_q == ST_IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    assign eff_size = ONLY_ALLOW_WORDS ? 2'd2 : bus.req_size;
    assign eff_off  = ONLY_ALLOW_WORDS ? 2'd0 : bus.req_address[1:0];
    assign req_widx = bus.req_address[ADDRESS_WIDTH-1:2];

    // An access crosses into the next word when its last byte lies past lane 3.
    assign crosses = ({1'b0, eff_off} + nbytes(eff_size)) > 3'd4;
    assign illegal = (eff_size == 2'd3) || (crosses && !ALLOW_MISALIGNED);

    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_error      = resp_error_q;
    assign bus.resp_read_value = resp_data_q;

    always_comb begin
        state_d       = state_q;
        resp_valid_d  = 1'b0;
        resp_error_d  = 1'b0;
        resp_data_d   = 32'd0;
        sp_widx_d     = sp_widx_q;
        sp_off_d      = sp_off_q;
        sp_size_d     = sp_size_q;
        sp_write_d    = sp_write_q;
        sp_unsigned_d = sp_unsigned_q;
        sp_wdata_d    = sp_wdata_q;
        sp_rdata_d    = sp_rdata_q;
        mem_we        = 4'd0;
        mem_widx      = req_widx;
        mem_wdata     = 32'd0;
        rbytes        = 32'd0;
        lane          = 0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else begin
                        // Request byte i maps to lane off+i; lanes past 3 belong to the next word.
                        for (int i = 0; i < 4; i++) begin
                            lane = int'(eff_off) + i;
                            if (i < int'(nbytes(eff_size)) && lane < 4) begin
                                if (bus.req_write) begin
                                    mem_we[lane]           = 1'b1;
                                    mem_wdata[lane*8 +: 8] = bus.req_write_value[i*8 +: 8];
                                end else begin
                                    rbytes[i*8 +: 8] = mem_q[req_widx][lane*8 +: 8];
                                end
                            end
                        end
                        if (crosses) begin
                            state_d       = ST_SPLIT;
                            sp_widx_d     = req_widx;
                            sp_off_d      = eff_off;
                            sp_size_d     = eff_size;
                            sp_write_d    = bus.req_write;
                            sp_unsigned_d = bus.req_unsigned;
                            sp_wdata_d    = bus.req_write_value;
                            sp_rdata_d    = rbytes;
                        end else begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = bus.req_write ? 32'd0 : extend(rbytes, eff_size, bus.req_unsigned);
                        end
                    end
                end
            end
            ST_SPLIT: begin
                // Next word index wraps naturally at the top of the bank.
                mem_widx = sp_widx_q + 1'b1;
                rbytes   = sp_rdata_q;
                for (int i = 0; i < 4; i++) begin
                    lane = int'(sp_off_q) + i;
                    if (i < int'(nbytes(sp_size_q)) && lane >= 4) begin
                        if (sp_write_q) begin
                            mem_we[lane-4]             = 1'b1;
                            mem_wdata[(lane-4)*8 +: 8] = sp_wdata_q[i*8 +: 8];
                        end else begin
                            rbytes[i*8 +: 8] = mem_q[mem_widx][(lane-4)*8 +: 8];
                        end
                    end
                end
                resp_valid_d = 1'b1;
                resp_data_d  = sp_write_q ? 32'd0 : extend(rbytes, sp_size_q, sp_unsigned_q);
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_data_q   <= 32'd0;
            sp_widx_q     <= '0;
            sp_off_q      <= 2'd0;
            sp_size_q     <= 2'd0;
            sp_write_q    <= 1'b0;
            sp_unsigned_q <= 1'b0;
            sp_wdata_q    <= 32'd0;
            sp_rdata_q    <= 32'd0;
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            resp_valid_q  <= resp_valid_d;
            resp_error_q  <= resp_error_d;
            resp_data_q   <= resp_data_d;
            sp_widx_q     <= sp_widx_d;
            sp_off_q      <= sp_off_d;
            sp_size_q     <= sp_size_d;
            sp_write_q    <= sp_write_d;
            sp_unsigned_q <= sp_unsigned_d;
            sp_wdata_q    <= sp_wdata_d;
            sp_rdata_q    <= sp_rdata_d;
            for (int l = 0; l < 4; l++) begin
                if (mem_we[l]) begin
                    mem_q[mem_widx][l*8 +: 8] <= mem_wdata[l*8 +: 8];
                end
            end
        end
    end
endmodule
